// File: rtl/rr_arbiter4.sv
// rr_arbiter4 - four-requester round-robin arbiter with registered grant.
//
// Produces a registered 2-bit grant index (feeds the downstream 2-to-4
// decoder) plus a grant-valid flag. A grant is held until the owner
// strobes done, drops its request, or (optionally) hits the hold limit.
// Every grant is followed by at least one idle cycle with gnt_valid = 0.
//
// Build option: define ARB_TIMEOUT_EN to enable the hold-limit counter
// and the timeout pulse. When it is undefined, no counter is built and
// timeout is constant 0.
//
// Parameters:
//   HOLD_MAX  maximum grant length in cycles (1..255), timeout build only
// Ports:
//   clk       clock, rising edge
//   rst_n     synchronous active-low reset
//   req[3:0]  request vector, bit i = requester i
//   done      owner release strobe, sampled only while gnt_valid = 1
//   gnt_idx   registered index of current/last granted requester
//   gnt_valid registered grant-active flag
//   timeout   registered one-cycle pulse after a forced release
module rr_arbiter4 #(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_range
    $error("rr_arbiter4: HOLD_MAX must be in 1..255");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state;
  logic [1:0] last;
  logic [1:0] winner;
  logic [1:0] cand;
  logic       rel;

  // Scan from the highest offset down so the nearest requester after
  // `last` is the one left in `winner`; offset 4 wraps back to `last`.
  always_comb begin
    winner = last;
    cand   = '0;
    for (int unsigned k = 4; k >= 1; k--) begin
      cand = last + k[1:0];
      if (req[cand]) winner = cand;
    end
  end

  assign rel = done | ~req[gnt_idx];

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      last      <= 2'd3;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (|req) begin
            gnt_idx   <= winner;
            gnt_valid <= 1'b1;
            last      <= winner;
            cnt       <= 8'd1;
            state     <= GRANT;
          end
        end
        GRANT: begin
          // A normal release takes precedence over the hold limit.
          if (rel) begin
            gnt_valid <= 1'b0;
            state     <= IDLE;
          end else if (cnt == HOLD_LIM) begin
            gnt_valid <= 1'b0;
            timeout   <= 1'b1;
            state     <= IDLE;
          end else if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign timeout = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      last      <= 2'd3;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            gnt_idx   <= winner;
            gnt_valid <= 1'b1;
            last      <= winner;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (rel) begin
            gnt_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed self-checking bench for rr_arbiter4 (HOLD_MAX = 4).
// Expected outputs are queued when each step's inputs are driven and
// compared once the following clock edge has produced the DUT response.
module tb_rr_arbiter4;

`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  typedef struct {
    logic       v;
    logic [1:0] idx;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  int   total;
  int   passed;

  rr_arbiter4 #(.HOLD_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one cycle of stimulus, queue its expected result, then check
  // the outputs #1 after the edge that consumes it.
  task automatic step(input logic r, input logic [3:0] rq, input logic d,
                      input logic ev, input logic [1:0] ei, input logic et,
                      input string tag);
    exp_t e;
    rst_n = r;
    req   = rq;
    done  = d;
    e.v = ev; e.idx = ei; e.to = et;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++;
      $error("FAIL %s.queue: observed empty expected 1 entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".valid"}, {1'b0, gnt_valid}, {1'b0, e.v});
      chk({tag, ".idx"},   gnt_idx,           e.idx);
      chk({tag, ".to"},    {1'b0, timeout},   {1'b0, e.to});
    end
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst_n  = 1'b0;
    req    = '0;
    done   = 1'b0;

    // reset state
    step(0, 4'b0000, 0, 0, 2'd0, 0, "rst");

    // single requester 2, done in 3rd grant cycle
    step(1, 4'b0100, 0, 1, 2'd2, 0, "t1.arb");
    step(1, 4'b0100, 0, 1, 2'd2, 0, "t1.c2");
    step(1, 4'b0100, 0, 1, 2'd2, 0, "t1.c3");
    step(1, 4'b0100, 1, 0, 2'd2, 0, "t1.done");

    // all requesting with done every grant cycle: 0,1,2,3,0
    step(0, 4'b0000, 0, 0, 2'd0, 0, "t2.rst");
    step(1, 4'b1111, 1, 1, 2'd0, 0, "t2.g0");
    step(1, 4'b1111, 1, 0, 2'd0, 0, "t2.r0");
    step(1, 4'b1111, 1, 1, 2'd1, 0, "t2.g1");
    step(1, 4'b1111, 1, 0, 2'd1, 0, "t2.r1");
    step(1, 4'b1111, 1, 1, 2'd2, 0, "t2.g2");
    step(1, 4'b1111, 1, 0, 2'd2, 0, "t2.r2");
    step(1, 4'b1111, 1, 1, 2'd3, 0, "t2.g3");
    step(1, 4'b1111, 1, 0, 2'd3, 0, "t2.r3");
    step(1, 4'b1111, 1, 1, 2'd0, 0, "t2.g0b");
    step(1, 4'b1111, 1, 0, 2'd0, 0, "t2.r0b");

    // wrap-around
    step(1, 4'b1000, 0, 1, 2'd3, 0, "t3.g3");
    step(1, 4'b1000, 1, 0, 2'd3, 0, "t3.r3");
    step(1, 4'b1001, 0, 1, 2'd0, 0, "t3.wrap0");
    step(1, 4'b1001, 1, 0, 2'd0, 0, "t3.r0");
    step(1, 4'b1001, 0, 1, 2'd3, 0, "t3.wrap3");
    step(1, 4'b1001, 1, 0, 2'd3, 0, "t3.r3b");

    // request drop, other bits ignored while granted
    step(1, 4'b0010, 0, 1, 2'd1, 0, "t4.g1");
    step(1, 4'b1011, 0, 1, 2'd1, 0, "t4.frozen");
    step(1, 4'b0000, 0, 0, 2'd1, 0, "t4.drop");
    step(1, 4'b0000, 0, 0, 2'd1, 0, "t4.idle");

    // hold limit 4 with req 0011 held and done low
    step(1, 4'b0011, 0, 1, 2'd0, 0, "t5.g0");
    step(1, 4'b0011, 0, 1, 2'd0, 0, "t5.c2");
    step(1, 4'b0011, 0, 1, 2'd0, 0, "t5.c3");
    step(1, 4'b0011, 0, 1, 2'd0, 0, "t5.c4");
    step(1, 4'b0011, 0, TO_EN ? 1'b0 : 1'b1, 2'd0, TO_EN, "t5.force0");
    step(1, 4'b0011, 0, 1'b1, TO_EN ? 2'd1 : 2'd0, 0, "t5.g1");
    step(1, 4'b0011, 0, 1'b1, TO_EN ? 2'd1 : 2'd0, 0, "t5.g1c2");
    step(1, 4'b0011, 0, 1'b1, TO_EN ? 2'd1 : 2'd0, 0, "t5.g1c3");
    step(1, 4'b0011, 0, 1'b1, TO_EN ? 2'd1 : 2'd0, 0, "t5.g1c4");
    step(1, 4'b0011, 0, TO_EN ? 1'b0 : 1'b1, TO_EN ? 2'd1 : 2'd0, TO_EN, "t5.force1");
    step(1, 4'b0000, 1, 0, TO_EN ? 2'd1 : 2'd0, 0, "t5.idle");

    // done in the 4th cycle coincides with the limit: no timeout
    step(1, 4'b0001, 0, 1, 2'd0, 0, "t6.g0");
    step(1, 4'b0001, 0, 1, 2'd0, 0, "t6.c2");
    step(1, 4'b0001, 0, 1, 2'd0, 0, "t6.c3");
    step(1, 4'b0001, 0, 1, 2'd0, 0, "t6.c4");
    step(1, 4'b0001, 1, 0, 2'd0, 0, "t6.done");
    step(1, 4'b0000, 0, 0, 2'd0, 0, "t6.nopulse");

    // reset in the middle of a grant (at the hold-limit cycle)
    step(1, 4'b1111, 0, 1, 2'd1, 0, "t7.g1");
    step(1, 4'b1111, 0, 1, 2'd1, 0, "t7.c2");
    step(1, 4'b1111, 0, 1, 2'd1, 0, "t7.c3");
    step(1, 4'b1111, 0, 1, 2'd1, 0, "t7.c4");
    step(0, 4'b1111, 0, 0, 2'd0, 0, "t7.rst");
    step(1, 4'b1111, 0, 1, 2'd0, 0, "t7.g0");
    step(1, 4'b0000, 0, 0, 2'd0, 0, "t7.drop");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter with a registered grant handshake. It produces the 2-bit grant index that feeds the 2-to-4 decoder stage directly downstream. The one-hot select that the decoder generates is therefore driven from a clean, registered source. Each grant is held until the owner signals completion, drops its request, or (optionally) exceeds a hold limit. A guaranteed idle gap separates consecutive grants.

## Interface
- `HOLD_MAX`, default 16: maximum grant length in cycles. Legal range 1..255. Used only when `ARB_TIMEOUT_EN` is defined.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `req` input 4: request vector; bit i is requester i.
- `done` input 1: owner's release strobe, sampled only while `gnt_valid` = 1.
- `gnt_idx` output 2: index of the current or last granted requester; registered. Feeds the decoder's `in`.
- `gnt_valid` output 1: grant active; registered.
- `timeout` output 1: one-cycle pulse marking a forced release; registered. Tied 0 when `ARB_TIMEOUT_EN` is undefined.

## Operation
- Reset values (rst_n = 0 at an edge):
  - `gnt_idx` = 2'b00, `gnt_valid` = 0, `timeout` = 0.
  - State IDLE, hold counter = 0.
  - Priority pointer `last` = 2'd3, so requester 0 has top priority after reset.
- State machine has two states, IDLE and GRANT.
- IDLE:
  - `gnt_valid` = 0.
  - If `req` != 0, select the first set bit scanning `last`+1, `last`+2, `last`+3, `last` (mod 4, wrapping 3 -> 0).
  - On that edge, load `gnt_idx`, set `gnt_valid` = 1, set `last` = winner, load counter = 1, go to GRANT.
  - If `req` == 0, stay in IDLE. `gnt_idx` holds its previous value.
- GRANT:
  - `gnt_idx` is frozen; changes to `req` on other bits are ignored.
  - The release condition is `done` = 1, OR `req[gnt_idx]` = 0, OR a timeout (see Configuration).
  - On release: `gnt_valid` -> 0 and the state returns to IDLE.
  - Otherwise the counter increments, saturating at 255.
- Simultaneous events:
  - If `done` and the timeout condition occur in the same cycle, the release is normal and `timeout` stays 0.
  - A request drop together with the timeout condition is also a normal release.
- Fairness: the requester just served has lowest priority in the next arbitration. With all four requesting, grants rotate 0,1,2,3,0...
- Reset mid-grant: at the first edge with `rst_n` = 0, all state returns to reset values. No partial release, no `timeout` pulse.

## Timing
- Arbitration latency: `req` sampled at edge n gives `gnt_valid` = 1 and a valid `gnt_idx` after edge n.
- Release latency: a release condition sampled at edge m gives `gnt_valid` = 0 after edge m.
- Minimum gap between grants is one IDLE cycle with `gnt_valid` = 0. The minimum grant length is one cycle.
- The downstream decoder sees `gnt_idx` stable for the whole interval in which `gnt_valid` = 1.
- `timeout` is high for exactly the one IDLE cycle that follows a forced release.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- Defined:
  - A forced release occurs when counter == `HOLD_MAX` in GRANT, `done` = 0 and `req[gnt_idx]` = 1.
  - `timeout` pulses for one cycle after that release, and `last` advances normally.
  - The grant length is therefore at most `HOLD_MAX` cycles.
- Undefined:
  - No counter logic is built and `timeout` is constant 0.
  - A grant lasts until `done` or a request drop, with no upper bound.

## Test plan
- Reset, then `req` = 4'b0100 held with `done` pulsed in the 3rd grant cycle -> `gnt_idx` = 2 and `gnt_valid` = 1 one cycle after the request, `gnt_valid` = 0 after the `done` edge.
- `req` = 4'b1111 held, `done` = 1 on every grant cycle -> `gnt_idx` sequence 0,1,2,3,0 with `gnt_valid` alternating 1,0.
- Wrap-around: after a grant to 3, `req` = 4'b1001 -> next grant is 0. After a grant to 0, the same request -> next grant is 3.
- Request drop: grant to 1, deassert `req[1]` with `done` = 0 -> `gnt_valid` falls after that edge and `timeout` = 0.
- `ARB_TIMEOUT_EN`, `HOLD_MAX` = 4, `req` = 4'b0011 held, `done` = 0:
  - grant 0 with `gnt_valid` high for exactly 4 cycles;
  - `timeout` = 1 for one cycle;
  - then grant 1 for 4 cycles.
  - With `done` = 1 in cycle 4, there is no `timeout` pulse.
- Drive `rst_n` = 0 for one edge in the middle of a grant -> all outputs return to zero and `timeout` = 0. With `req` = 4'b1111, the next grant goes to 0.
